// File: rtl/match_accum_pkg.sv
// match_accum_pkg: shared state/mode encodings for the conditional accumulator
package match_accum_pkg;
  localparam logic [1:0] ENC_RUN = 2'd0;
  localparam logic [1:0] ENC_HIT = 2'd1;
  localparam logic [1:0] ENC_LOCK = 2'd2;
  localparam logic [1:0] ENC_EQ = 2'd0;
  localparam logic [1:0] ENC_LE = 2'd1;
  localparam logic [1:0] ENC_ALWAYS = 2'd2;
  localparam logic [1:0] ENC_HOLD = 2'd3;
  typedef enum logic [1:0] {RUN = ENC_RUN, HIT = ENC_HIT, LOCK = ENC_LOCK} state_e;
  typedef enum logic [1:0] {EQ = ENC_EQ, LE = ENC_LE, ALWAYS = ENC_ALWAYS, HOLD = ENC_HOLD} mode_e;
endpackage

// File: rtl/match_accum_add.sv
// match_accum_add: WIDTH-bit adder with carry out; saturates when MATCH_ACCUM_SAT_EN is defined
module match_accum_add #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  logic [WIDTH:0] s;
  assign s = {1'b0, a} + {1'b0, b};
  assign carry = s[WIDTH];
`ifdef MATCH_ACCUM_SAT_EN
  assign sum = s[WIDTH] ? '1 : s[WIDTH-1:0];
`else
  assign sum = s[WIDTH-1:0];
`endif
endmodule

// File: rtl/match_accum_fsm.sv
// match_accum_fsm: conditional accumulator with target-hit counter and lock FSM (MATCH_ACCUM_SAT_EN selects saturating add)
module match_accum_fsm
  import match_accum_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int INIT = 1,
  parameter int TARGET = 2,
  parameter int LOCK_HITS = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] add,
  output logic [WIDTH-1:0] x_out,
  output logic             z1,
  output logic             ovf,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [1:0]       state
);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] TGT_V = WIDTH'(TARGET);
  localparam logic [CNT_W-1:0] LOCK_V = CNT_W'(LOCK_HITS);
  logic [WIDTH-1:0] x_q, x_d, nx;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, cnt_inc;
  logic             ovf_q, ovf_d, carry, cond, upd, hit;
  state_e           state_q, state_d;
  match_accum_add #(.WIDTH(WIDTH)) u_add (.a(x_q), .b(add), .sum(nx), .carry(carry));
  // next-state: clr beats update; LOCK freezes everything; stray encodings fall back to RUN
  always_comb begin
    cond = mode == ENC_EQ ? add == x_q : mode == ENC_LE ? add <= x_q : mode == ENC_ALWAYS;
    upd = en && cond && state_q != LOCK;
    hit = upd && nx == TGT_V;
    cnt_inc = hit_cnt_q == '1 ? hit_cnt_q : hit_cnt_q + 1'b1;
    x_d = clr ? INIT_V : upd ? nx : x_q;
    ovf_d = !clr && upd && carry;
    hit_cnt_d = clr ? '0 : hit ? cnt_inc : hit_cnt_q;
    state_d = clr ? RUN
            : state_q == LOCK ? LOCK
            : state_q != RUN && state_q != HIT ? RUN
            : hit ? (cnt_inc == LOCK_V ? LOCK : HIT)
            : upd ? RUN : state_q;
  end
  // registered state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= INIT_V;
      ovf_q <= 1'b0;
      hit_cnt_q <= '0;
      state_q <= RUN;
    end else begin
      x_q <= x_d;
      ovf_q <= ovf_d;
      hit_cnt_q <= hit_cnt_d;
      state_q <= state_d;
    end
  end
  assign x_out = x_q;
  assign z1 = x_q == TGT_V;
  assign ovf = ovf_q;
  assign hit_cnt = hit_cnt_q;
  assign state = state_q;
endmodule

// File: tb/tb_match_accum_fsm.sv
// tb_match_accum_fsm: directed self-checking bench for match_accum_fsm (default and WIDTH=4 instances)
module tb_match_accum_fsm;
  logic clk = 0, reset = 0, en = 0, clr = 0, en4 = 0, clr4 = 0;
  logic [1:0] mode = 0, mode4 = 0, add = 0, x_out, state, state4;
  logic [3:0] add4 = 0, x4, cnt, cnt4;
  logic z1, ovf, z14, ovf4;
  int checks = 0, errors = 0;
  match_accum_fsm dut (.clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode), .add(add),
    .x_out(x_out), .z1(z1), .ovf(ovf), .hit_cnt(cnt), .state(state));
  match_accum_fsm #(.WIDTH(4), .INIT(1), .TARGET(9), .LOCK_HITS(3), .CNT_W(4)) dut4 (.clk(clk),
    .reset(reset), .en(en4), .clr(clr4), .mode(mode4), .add(add4), .x_out(x4), .z1(z14),
    .ovf(ovf4), .hit_cnt(cnt4), .state(state4));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1; en = 1; add = 3; mode = 2;
    tick();
    checks++;
    if ({x_out, z1, ovf, cnt, state} !== {2'd1, 1'b0, 1'b0, 4'd0, 2'd0}) begin
      errors++; $display("FAIL reset x/z1/ovf/cnt/st got %b want %b", {x_out, z1, ovf, cnt, state}, {2'd1, 1'b0, 1'b0, 4'd0, 2'd0});
    end
    reset = 0; en = 0;
  endtask
  task automatic test_eq();
    mode = 0; add = 1; en = 1;
    tick();
    checks++;
    if ({x_out, z1, ovf, cnt, state} !== {2'd2, 1'b1, 1'b0, 4'd1, 2'd1}) begin
      errors++; $display("FAIL eq_hit got %b want %b", {x_out, z1, ovf, cnt, state}, {2'd2, 1'b1, 1'b0, 4'd1, 2'd1});
    end
    add = 3;
    tick();
    checks++;
    if ({x_out, z1, ovf, cnt, state} !== {2'd2, 1'b1, 1'b0, 4'd1, 2'd1}) begin
      errors++; $display("FAIL eq_nomatch got %b want %b", {x_out, z1, ovf, cnt, state}, {2'd2, 1'b1, 1'b0, 4'd1, 2'd1});
    end
  endtask
  task automatic test_wrap();
    logic [9:0] exp;
`ifdef MATCH_ACCUM_SAT_EN
    exp = {2'd3, 1'b0, 1'b1, 4'd1, 2'd0};
`else
    exp = {2'd1, 1'b0, 1'b1, 4'd1, 2'd0};
`endif
    mode = 2; add = 3; en = 1;
    tick();
    checks++;
    if ({x_out, z1, ovf, cnt, state} !== exp) begin
      errors++; $display("FAIL wrap got %b want %b", {x_out, z1, ovf, cnt, state}, exp);
    end
    en = 0;
    exp[6] = 1'b0;
    tick();
    checks++;
    if ({x_out, z1, ovf, cnt, state} !== exp) begin
      errors++; $display("FAIL wrap_ovf_pulse got %b want %b", {x_out, z1, ovf, cnt, state}, exp);
    end
  endtask
  task automatic test_lock();
    logic [9:0] exp [7];
    exp = '{{2'd1, 1'b0, 1'b0, 4'd0, 2'd0}, {2'd2, 1'b1, 1'b0, 4'd1, 2'd1}, {2'd2, 1'b1, 1'b0, 4'd2, 2'd1},
            {2'd2, 1'b1, 1'b0, 4'd3, 2'd2}, {2'd2, 1'b1, 1'b0, 4'd3, 2'd2}, {2'd2, 1'b1, 1'b0, 4'd3, 2'd2},
            {2'd1, 1'b0, 1'b0, 4'd0, 2'd0}};
    for (int i = 0; i < 7; i++) begin
      clr = i == 0 || i == 6;
      en = 1; mode = 2;
      add = i == 1 || i == 4 ? 2'd1 : i == 5 ? 2'd3 : 2'd0;
      tick();
      checks++;
      if ({x_out, z1, ovf, cnt, state} !== exp[i]) begin
        errors++; $display("FAIL lock step %0d got %b want %b", i, {x_out, z1, ovf, cnt, state}, exp[i]);
      end
    end
    clr = 0; en = 0;
  endtask
  task automatic test_simultaneous();
    mode = 2; add = 1; en = 1;
    tick();
    checks++;
    if ({x_out, z1, ovf, cnt, state} !== {2'd2, 1'b1, 1'b0, 4'd1, 2'd1}) begin
      errors++; $display("FAIL simul_setup got %b want %b", {x_out, z1, ovf, cnt, state}, {2'd2, 1'b1, 1'b0, 4'd1, 2'd1});
    end
    reset = 1; clr = 1; add = 0;
    tick();
    checks++;
    if ({x_out, z1, ovf, cnt, state} !== {2'd1, 1'b0, 1'b0, 4'd0, 2'd0}) begin
      errors++; $display("FAIL simul_reset got %b want %b", {x_out, z1, ovf, cnt, state}, {2'd1, 1'b0, 1'b0, 4'd0, 2'd0});
    end
    reset = 0; clr = 1; add = 3;
    tick();
    checks++;
    if ({x_out, z1, ovf, cnt, state} !== {2'd1, 1'b0, 1'b0, 4'd0, 2'd0}) begin
      errors++; $display("FAIL simul_clr got %b want %b", {x_out, z1, ovf, cnt, state}, {2'd1, 1'b0, 1'b0, 4'd0, 2'd0});
    end
    clr = 0; en = 0;
  endtask
  task automatic test_width4();
    logic [3:0] adds [4] = '{4'd1, 4'd2, 4'd4, 4'd1};
    logic [3:0] xs [4] = '{4'd2, 4'd4, 4'd8, 4'd9};
    mode4 = 1; en4 = 1;
    for (int i = 0; i < 4; i++) begin
      add4 = adds[i];
      tick();
      checks++;
      if ({x4, z14, ovf4} !== {xs[i], i == 3, 1'b0}) begin
        errors++; $display("FAIL width4 step %0d x/z1/ovf got %b want %b", i, {x4, z14, ovf4}, {xs[i], i == 3, 1'b0});
      end
    end
    checks++;
    if ({cnt4, state4} !== {4'd1, 2'd1}) begin
      errors++; $display("FAIL width4 cnt/state got %b want %b", {cnt4, state4}, {4'd1, 2'd1});
    end
    en4 = 0;
  endtask
  initial begin
    test_reset();
    test_eq();
    test_wrap();
    test_lock();
    test_simultaneous();
    test_width4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
